ecg_sample_buf_ctrl: RTL and testbench

//  Ring-buffer controller for the 4096x32 true-dual-port ECG sample BRAM. Port A is the write

---
 rtl/ecg_sample_buf_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ecg_sample_buf_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_sample_buf_ctrl.sv
// ecg_sample_buf_ctrl: ring-buffer controller for a true-dual-port ECG sample BRAM.
// Port A stores the incoming sample stream at the write pointer; port B streams the
// oldest Blk_len samples out through a small skid FIFO that absorbs the BRAM read latency.
module ecg_sample_buf_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              blk_start_i,
    input  logic [ADDR_W:0]   blk_len_i,
    output logic              blk_err_o,
    output logic              busy_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic [ADDR_W:0]   count_o,
    output logic              ovf_o,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [DATA_W-1:0] dina_o,
    output logic              enb_o,
    output logic [ADDR_W-1:0] addrb_o,
    input  logic [DATA_W-1:0] doutb_i
);
    // Skid holds every word that can be outstanding, so a stall never drops BRAM data.
    localparam int SK = RD_LAT + 1;
    // Occupancy width: in-flight reads plus skid entries, with headroom.
    localparam int OW = $clog2(2 * SK + 1);
    localparam logic [ADDR_W:0]   FULL    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]          count_q, count_d;
    logic [ADDR_W:0]          rem_q, rem_d;
    logic                     busy_q, busy_d;
    logic                     blk_err_q, blk_err_d;
    logic                     ovf_q;
    logic [RD_LAT-1:0]        pipe_vld_q, pipe_last_q;
    logic [SK-1:0][DATA_W-1:0] skid_data_q, skid_data_d;
    logic [SK-1:0]            skid_last_q, skid_last_d;
    logic [OW-1:0]            skid_cnt_q, skid_cnt_d;
    logic [OW-1:0]            inflight;
    logic                     room, issue, wr_en, pop;
    logic                     arrive, arrive_last, skid_nempty;
    logic [DATA_W-1:0]        head_data;
    logic                     head_last;

    // Write side: accept whenever not full; reset masks the BRAM strobes.
    assign in_ready_o = (count_q != FULL);
    assign wr_en      = in_valid_i & in_ready_o & ~rst_i;
    assign ena_o      = wr_en;
    assign wea_o      = wr_en;
    assign addra_o    = wr_ptr_q;
    assign dina_o     = wr_en ? in_data_i : '0;

    // Read side: the word issued RD_LAT cycles ago is on Doutb now.
    assign arrive      = pipe_vld_q[RD_LAT-1];
    assign arrive_last = pipe_last_q[RD_LAT-1];
    assign skid_nempty = (skid_cnt_q != '0);
    assign head_data   = skid_nempty ? skid_data_q[0] : doutb_i;
    assign head_last   = skid_nempty ? skid_last_q[0] : arrive_last;
    assign out_valid_o = skid_nempty | arrive;
    assign out_data_o  = out_valid_o ? head_data : '0;
    assign out_last_o  = out_valid_o & head_last;
    assign pop         = out_valid_o & out_ready_i;

    assign enb_o     = issue;
    assign addrb_o   = rd_ptr_q;
    assign count_o   = count_q;
    assign busy_o    = busy_q;
    assign blk_err_o = blk_err_q;
    assign ovf_o     = ovf_q;

    // Outstanding words = reads in the BRAM pipe plus words parked in the skid.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OW'(pipe_vld_q[i]);
        end
        room = (inflight + skid_cnt_q) < OW'(SK);
    end

    // Block FSM: validate requests, issue reads while room remains, wait for the last handshake.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        blk_err_d = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (blk_start_i) begin
                    if ((blk_len_i != '0) && (blk_len_i <= count_q)) begin
                        rem_d   = blk_len_i;
                        busy_d  = 1'b1;
                        state_d = BURST;
                    end else begin
                        blk_err_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if ((rem_q != '0) && room) begin
                    issue = 1'b1;
                    rem_d = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last_o) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stored-sample count: a write and a read in the same cycle cancel out.
    always_comb begin
        count_d = count_q + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, issue};
    end

    // Skid FIFO (head at index 0): pop shifts down, an arriving word that was not
    // handed straight through lands behind the remaining entries.
    always_comb begin
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_cnt_d  = skid_cnt_q;
        if (pop && skid_nempty) begin
            for (int i = 0; i < SK - 1; i++) begin
                skid_data_d[i] = skid_data_q[i+1];
                skid_last_d[i] = skid_last_q[i+1];
            end
            skid_cnt_d = skid_cnt_q - OW'(1);
        end
        if (arrive && !(pop && !skid_nempty)) begin
            for (int i = 0; i < SK; i++) begin
                if (OW'(i) == skid_cnt_d) begin
                    skid_data_d[i] = doutb_i;
                    skid_last_d[i] = arrive_last;
                end
            end
            skid_cnt_d = skid_cnt_d + OW'(1);
        end
    end

    // Control state, pointers and counters; reset discards everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            blk_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            blk_err_q <= blk_err_d;
            ovf_q     <= ovf_q | (in_valid_i & ~in_ready_o);
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (issue) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Read-latency tracker and skid storage; the last flag rides along with each read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            skid_data_q <= '0;
            skid_last_q <= '0;
            skid_cnt_q  <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue & (rem_q == CNT_ONE);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            skid_cnt_q  <= skid_cnt_d;
        end
    end

endmodule

// File: tb/tb_ecg_sample_buf_ctrl.sv
// tb_ecg_sample_buf_ctrl: table-driven block requests plus hand-written fill/overflow,
// backpressure, wrap, continuous-write and mid-burst reset sequences. A negedge monitor
// keeps an in-order scoreboard of accepted writes and checks every output handshake.
module tb_ecg_sample_buf_ctrl;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int RL    = 1;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          blk_start = 1'b0;
    logic [AW:0]   blk_len = '0;
    logic          blk_err, busy, out_valid, out_last;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b1;
    logic [AW:0]   count;
    logic          ovf, ena, wea, enb;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina;
    logic [DW-1:0] doutb;

    always #5 clk = ~clk;

    ecg_sample_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .blk_start_i(blk_start), .blk_len_i(blk_len), .blk_err_o(blk_err), .busy_o(busy),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_ready_i(out_ready), .count_o(count), .ovf_o(ovf),
        .ena_o(ena), .wea_o(wea), .addra_o(addra), .dina_o(dina),
        .enb_o(enb), .addrb_o(addrb), .doutb_i(doutb)
    );

    // 4096x32 BRAM with one cycle of port-B read latency
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dina;
        if (enb) doutb <= mem[addrb];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard state
    logic [DW-1:0] sb[$];
    int            mcount, pend, acc;
    int            blk_len_m = 0;
    logic [AW-1:0] mwr, mrd, last_addrb;
    bit            stall_prev, saw_wrap, wr_m;
    logic [DW-1:0] stall_data, exp_d;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mcount = 0; pend = 0; acc = 0;
            mwr = '0; mrd = '0; last_addrb = '0;
            stall_prev = 1'b0;
        end else begin
            wr_m = in_valid && (mcount != DEPTH);
            if (in_valid || enb) check("count", count, mcount);
            if (in_valid) check("in_ready", in_ready, mcount != DEPTH);
            if (wr_m) begin
                check("porta", {ena, wea, addra, dina}, {1'b1, 1'b1, mwr, in_data});
                sb.push_back(in_data);
                mwr = mwr + 1'b1;
            end
            if (enb) begin
                check("issue_room", pend < RL + 1, 1);
                check("addrb", addrb, mrd);
                if (addrb == '0 && last_addrb == AW'(DEPTH - 1)) saw_wrap = 1'b1;
                last_addrb = addrb;
                mrd = mrd + 1'b1;
                pend++;
            end
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                acc++;
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out_extra: got 0x%0h, expected no output", out_data);
                end else begin
                    exp_d = sb.pop_front();
                    check("out_data", out_data, exp_d);
                end
                check("out_last", out_last, acc == blk_len_m);
                if (acc == blk_len_m) acc = 0;
                pend--;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            mcount = mcount + int'(wr_m) - int'(enb);
        end
    end

    logic [DW-1:0] wval = 32'h100;
    int            n_cont = 0;

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = wval; wval++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // rdy_mode 0: Out_ready high; 1: pattern 1,0,0,1,0,0,...
    task automatic run_block(input int len, input bit exp_err, input int rdy_mode,
                             input bit wr_cont, input int budget);
        bit done;
        int c;
        @(posedge clk); #1;
        blk_start = 1'b1; blk_len = len[AW:0];
        if (!exp_err) blk_len_m = len;
        @(posedge clk); #1;
        blk_start = 1'b0;
        @(negedge clk);
        check("blk_err", blk_err, exp_err);
        check("busy", busy, !exp_err);
        if (exp_err) begin
            @(negedge clk);
            check("blk_err_pulse", blk_err, 0);
            check("busy_idle", busy, 0);
        end else begin
            check("first_lat_lo", out_valid, 0);
            @(negedge clk);
            check("first_lat_hi", out_valid, 1);
            done = out_valid && out_ready && out_last;
            c = 0;
            while (!done && c < budget) begin
                @(posedge clk); #1;
                if (rdy_mode == 1) out_ready = (c % 3 == 0);
                if (wr_cont) begin
                    in_valid = 1'b1; in_data = wval; wval++; n_cont++;
                end
                @(negedge clk);
                done = out_valid && out_ready && out_last;
                c++;
            end
            check("block_done", done, 1);
            check("busy_before_fall", busy, 1);
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            check("busy_fall", busy, 0);
        end
    endtask

    typedef struct {
        int n_wr;
        int len;
        bit err;
        int cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int acc6, c6;
        tbl[0] = '{10, 4, 1'b0, 6};
        tbl[1] = '{0,  0, 1'b1, 6};
        tbl[2] = '{0,  7, 1'b1, 6};
        tbl[3] = '{0,  6, 1'b0, 0};
        tbl[4] = '{3,  5, 1'b1, 3};
        tbl[5] = '{0,  0, 1'b1, 3};
        tbl[6] = '{0,  3, 1'b0, 0};
        tbl[7] = '{1,  1, 1'b0, 0};

        // Reset state, with a write attempt held during reset
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_flags", {in_ready, blk_err, busy, out_valid, out_last, ovf, ena, wea, enb},
              9'b1_0000_0000);
        check("rst_count", count, 0);
        check("rst_addr", {addra, addrb, dina}, '0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Table: write, request, compare error/busy/data, then stored count
        for (int i = 0; i < 8; i++) begin
            write_n(tbl[i].n_wr);
            run_block(tbl[i].len, tbl[i].err, 0, 1'b0, 100);
            @(negedge clk);
            check("tbl_count", count, tbl[i].cnt);
        end

        // Fill to 4096, overflow, then drain all with Addrb wrapping
        write_n(DEPTH);
        @(negedge clk);
        check("full_ready", in_ready, 0);
        check("full_count", count, DEPTH);
        check("ovf_pre", ovf, 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ovf_set", ovf, 1);
        check("drop_count", count, DEPTH);
        run_block(DEPTH, 1'b0, 0, 1'b0, 5000);
        @(negedge clk);
        check("empty_count", count, 0);
        check("empty_ready", in_ready, 1);
        check("addrb_wrap", saw_wrap, 1);

        // Backpressure with Out_ready toggling 1,0,0
        write_n(8);
        run_block(8, 1'b0, 1, 1'b0, 200);
        @(negedge clk);
        check("bp_count", count, 0);

        // Move pointers to 4090, then a 16-sample burst with continuous writes across the wrap
        write_n(4068);
        run_block(4068, 1'b0, 0, 1'b0, 5000);
        write_n(16);
        run_block(16, 1'b0, 0, 1'b1, 200);
        @(negedge clk);
        check("cont_count", count, n_cont);
        run_block(n_cont, 1'b0, 0, 1'b0, 200);
        @(negedge clk);
        check("cont_drain", count, 0);

        // Reset after 3 of 8 words delivered
        write_n(8);
        @(posedge clk); #1;
        blk_start = 1'b1; blk_len = 13'd8; blk_len_m = 8;
        @(posedge clk); #1;
        blk_start = 1'b0;
        acc6 = 0; c6 = 0;
        while (acc6 < 3 && c6 < 50) begin
            @(negedge clk);
            if (out_valid && out_ready) acc6++;
            c6++;
        end
        check("mid_acc", acc6, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_flags", {out_valid, busy, in_ready, enb, ovf}, 5'b00100);
        check("mid_rst_count", count, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        write_n(4);
        run_block(4, 1'b0, 0, 1'b0, 100);
        @(negedge clk);
        check("post_rst_count", count, 0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
